// File: rtl/lane_scroller_if.sv
// Bus between the frog-game control logic and one road lane.
// The master drives the control inputs and the slave drives the lane state back.
interface lane_scroller_if #(
  parameter int LANE_WIDTH = 10
);
  logic                  i_Tick;
  logic                  i_Start;
  logic                  i_Pause;
  logic                  i_Load;
  logic [LANE_WIDTH-1:0] i_Pattern;
  logic [3:0]            i_Frog_Col;
  logic [LANE_WIDTH-1:0] o_Lane;
  logic                  o_Step;
  logic                  o_Hit;
  logic                  o_Running;

  modport master (
    output i_Tick, i_Start, i_Pause, i_Load,
    output i_Pattern, i_Frog_Col,
    input  o_Lane, o_Step, o_Hit, o_Running
  );

  modport slave (
    input  i_Tick, i_Start, i_Pause, i_Load,
    input  i_Pattern, i_Frog_Col,
    output o_Lane, o_Step, o_Hit, o_Running
  );
endinterface

// File: rtl/lane_scroller.sv
// One road lane: rotates a car bitmap every TICKS_PER_STEP ticks
// and reports whether a car sits under the frog column.
module lane_scroller #(
  parameter int                    LANE_WIDTH     = 10,
  parameter int                    TICKS_PER_STEP = 4,
  parameter bit                    DIRECTION      = 1'b0,
  parameter logic [LANE_WIDTH-1:0] INIT_PATTERN   = 10'b0011000110
) (
  input  logic i_Clk,
  input  logic i_Rst,
  lane_scroller_if.slave bus
);

  localparam int CW =
    (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [LANE_WIDTH-1:0] lane_q;
  logic [LANE_WIDTH-1:0] lane_rot;
  logic                  step_q, hit_q, run_q;
  logic                  count_en, wrap;

  // Pause wins over a same-cycle tick, so counting needs both.
  assign count_en = (state_q == RUN) && !bus.i_Pause && bus.i_Tick;
  assign wrap     = count_en && (cnt_q == LAST);

  generate
    if (DIRECTION) begin : g_left
      assign lane_rot = {lane_q[LANE_WIDTH-2:0], lane_q[LANE_WIDTH-1]};
    end else begin : g_right
      assign lane_rot = {lane_q[0], lane_q[LANE_WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_Start) state_d = RUN;
      RUN:     if (bus.i_Pause) state_d = PAUSED;
      PAUSED:  if (!bus.i_Pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == RUN);
    end
  end

  // A load overrides any step landing in the same cycle.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lane_q <= INIT_PATTERN;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else if (bus.i_Load) begin
      lane_q <= bus.i_Pattern;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else if (wrap) begin
      lane_q <= lane_rot;
      cnt_q  <= '0;
      step_q <= 1'b1;
    end else begin
      step_q <= 1'b0;
      if (count_en) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hit_q <= 1'b0;
    end else if (bus.i_Frog_Col < 4'(LANE_WIDTH)) begin
      hit_q <= lane_q[bus.i_Frog_Col];
    end else begin
      hit_q <= 1'b0;
    end
  end

  assign bus.o_Lane    = lane_q;
  assign bus.o_Step    = step_q;
  assign bus.o_Hit     = hit_q;
  assign bus.o_Running = run_q;

endmodule

// File: tb/tb_lane_scroller.sv
// Directed bench for lane_scroller: scoreboarded lane moves plus
// checks on pause, load priority, hit, wrap-around and async reset.
module tb_lane_scroller;

  localparam logic [9:0] INIT = 10'b0011000110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e;

  always #5 clk = ~clk;

  lane_scroller_if #(.LANE_WIDTH(10)) a ();
  lane_scroller_if #(.LANE_WIDTH(10)) b ();

  lane_scroller #(
    .LANE_WIDTH(10), .TICKS_PER_STEP(4),
    .DIRECTION(1'b0), .INIT_PATTERN(INIT)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .bus(a)
  );

  lane_scroller #(
    .LANE_WIDTH(10), .TICKS_PER_STEP(1),
    .DIRECTION(1'b1), .INIT_PATTERN(INIT)
  ) dut_l (
    .i_Clk(clk), .i_Rst(rst), .bus(b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic mv);
    a.i_Tick = 1'b1;
    cyc();
    chk("step_pulse", 32'(a.o_Step), 32'(mv));
    a.i_Tick = 1'b0;
    cyc();
    chk("step_clear", 32'(a.o_Step), 0);
    repeat (8) cyc();
  endtask

  // Every o_Step pulse must match a move the stimulus announced.
  always @(negedge clk) begin
    if (a.o_Step) begin
      chk("step_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("step_lane", 32'(a.o_Lane), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a.i_Tick = 0; a.i_Start = 0; a.i_Pause = 0; a.i_Load = 0;
    a.i_Pattern = '0; a.i_Frog_Col = 4'd12;
    b.i_Tick = 0; b.i_Start = 0; b.i_Pause = 0; b.i_Load = 0;
    b.i_Pattern = '0; b.i_Frog_Col = 4'd0;
    repeat (3) cyc();
    chk("rst_lane", 32'(a.o_Lane), 32'(INIT));
    chk("rst_step", 32'(a.o_Step), 0);
    chk("rst_hit", 32'(a.o_Hit), 0);
    chk("rst_run", 32'(a.o_Running), 0);
    rst = 1'b0;
    cyc();
    do_tick(1'b0);
    chk("idle_frozen", 32'(a.o_Lane), 32'(INIT));

    a.i_Start = 1'b1;
    cyc();
    a.i_Start = 1'b0;
    chk("running", 32'(a.o_Running), 1);
    repeat (3) do_tick(1'b0);
    chk("lane_hold", 32'(a.o_Lane), 32'(INIT));
    exp_q.push_back(10'b0001100011);
    do_tick(1'b1);
    chk("lane_move1", 32'(a.o_Lane), 32'(10'b0001100011));

    a.i_Load = 1'b1; a.i_Pattern = 10'b0000000001;
    cyc();
    a.i_Load = 1'b0;
    chk("load", 32'(a.o_Lane), 32'(10'b0000000001));
    repeat (3) do_tick(1'b0);
    exp_q.push_back(10'b1000000000);
    do_tick(1'b1);

    b.i_Start = 1'b1;
    cyc();
    b.i_Start = 1'b0;
    b.i_Load = 1'b1; b.i_Pattern = 10'b1000000000;
    cyc();
    b.i_Load = 1'b0;
    chk("l_load", 32'(b.o_Lane), 32'(10'b1000000000));
    b.i_Tick = 1'b1;
    cyc();
    b.i_Tick = 1'b0;
    chk("l_wrap", 32'(b.o_Lane), 32'(10'b0000000001));
    chk("l_step", 32'(b.o_Step), 1);

    repeat (2) do_tick(1'b0);
    a.i_Pause = 1'b1;
    do_tick(1'b0);
    chk("paused", 32'(a.o_Running), 0);
    repeat (4) do_tick(1'b0);
    chk("pause_hold", 32'(a.o_Lane), 32'(10'b1000000000));
    a.i_Pause = 1'b0;
    cyc();
    chk("resumed", 32'(a.o_Running), 1);
    do_tick(1'b0);
    exp_q.push_back(10'b0100000000);
    do_tick(1'b1);

    repeat (3) do_tick(1'b0);
    a.i_Tick = 1'b1; a.i_Load = 1'b1;
    a.i_Pattern = 10'b1111100000;
    cyc();
    chk("ld_step", 32'(a.o_Step), 0);
    chk("ld_lane", 32'(a.o_Lane), 32'(10'b1111100000));
    a.i_Tick = 1'b0; a.i_Load = 1'b0;
    repeat (9) cyc();
    repeat (3) do_tick(1'b0);
    chk("ld_norot", 32'(a.o_Lane), 32'(10'b1111100000));
    exp_q.push_back(10'b0111110000);
    do_tick(1'b1);

    a.i_Load = 1'b1; a.i_Pattern = 10'b0000001000;
    a.i_Frog_Col = 4'd3;
    cyc();
    a.i_Load = 1'b0;
    chk("hit_lat", 32'(a.o_Hit), 0);
    cyc();
    chk("hit_on", 32'(a.o_Hit), 1);
    a.i_Frog_Col = 4'd12;
    cyc();
    chk("hit_oor", 32'(a.o_Hit), 0);
    a.i_Frog_Col = 4'd3;
    repeat (3) do_tick(1'b0);
    chk("hit_back", 32'(a.o_Hit), 1);
    exp_q.push_back(10'b0000000100);
    do_tick(1'b1);
    chk("hit_moved", 32'(a.o_Hit), 0);
    a.i_Frog_Col = 4'd2;
    cyc();
    chk("hit_col2", 32'(a.o_Hit), 1);

    repeat (3) do_tick(1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_lane", 32'(a.o_Lane), 32'(INIT));
    chk("arst_hit", 32'(a.o_Hit), 0);
    chk("arst_run", 32'(a.o_Running), 0);
    chk("arst_step", 32'(a.o_Step), 0);
    cyc();
    rst = 1'b0;
    cyc();
    repeat (5) do_tick(1'b0);
    chk("post_lane", 32'(a.o_Lane), 32'(INIT));
    chk("post_run", 32'(a.o_Running), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_scroller.md
Name: lane_scroller

Overview:
- Consumes the single-cycle tick pulse produced by the clock divider stage and advances one road lane of the frog game.
- Holds a LANE_WIDTH-bit car bitmap and rotates it by one column every TICKS_PER_STEP ticks.
- Reports a registered collision flag for the frog column to the game-control FSM.
- Drives the lane bitmap to the display renderer.

Parameters:
- LANE_WIDTH, 10, number of columns in the lane; bit i = car present in column i.
- TICKS_PER_STEP, 4, i_Tick pulses per one-column move; legal range 1..255.
- DIRECTION, 0, 0 = cars move toward column 0 (rotate right: bit i takes bit i+1, bit W-1 takes bit 0); 1 = cars move toward column W-1 (rotate left).
- INIT_PATTERN, 10'b0011000110, lane bitmap after reset.

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  asynchronous, active-high reset
- i_Tick  input  1  one-cycle enable pulse from clock divider
- i_Start  input  1  IDLE -> RUN request (level, sampled each cycle)
- i_Pause  input  1  level; high holds lane motion
- i_Load  input  1  one-cycle load strobe for i_Pattern
- i_Pattern  input  LANE_WIDTH  new lane bitmap
- i_Frog_Col  input  4  frog column index
- o_Lane  output  LANE_WIDTH  current lane bitmap
- o_Step  output  1  one-cycle pulse, cycle after each lane move
- o_Hit  output  1  registered: car present under frog
- o_Running  output  1  high while state = RUN

Behaviour:
- Reset (async, any time, including mid-step): state=IDLE, o_Lane=INIT_PATTERN, tick counter=0, o_Step=0, o_Hit=0, o_Running=0.
- States:
  - IDLE: lane frozen. i_Start=1 -> RUN.
  - RUN: counts ticks. i_Pause=1 -> PAUSED.
  - PAUSED: lane and counter frozen; i_Tick ignored. i_Pause=0 -> RUN.
- RUN with i_Pause=1 and i_Tick=1 in the same cycle: pause wins; the tick is not counted.
- Tick counter: width ceil(log2(TICKS_PER_STEP)), minimum 1 bit. Advances only in RUN on i_Tick.
  - On i_Tick with counter = TICKS_PER_STEP-1: counter <= 0, o_Lane rotates one position per DIRECTION, o_Step=1 on the next cycle only.
  - Otherwise on i_Tick: counter+1.
  - TICKS_PER_STEP=1: every tick moves the lane.
- Rotation is circular. Cars leaving one edge reappear at the opposite edge the same cycle. Bit count of o_Lane is invariant under rotation.
- i_Load=1 (any state): o_Lane <= i_Pattern, counter <= 0, state unchanged.
  - i_Load has priority over a same-cycle step; no rotation occurs that cycle and o_Step stays 0.
- o_Hit <= (i_Frog_Col < LANE_WIDTH) ? o_Lane[i_Frog_Col] : 0, registered every cycle in all states.
  - Latency: one cycle after o_Lane/i_Frog_Col change.
  - Out-of-range column never asserts o_Hit.
- o_Running is registered with the state; high exactly while in RUN.
- No X propagation: all registers have explicit reset values; no latches.

Test Plan:
- Reset then i_Start=1, TICKS_PER_STEP=4, DIRECTION=0, tick every 10 clocks -> o_Lane 0011000110 -> 0001100011 after 4th tick; o_Step high exactly one cycle after that move; o_Running=1.
- Wrap-around: load 0000000001, DIRECTION=0, 1 step -> 1000000000. With DIRECTION=1, load 1000000000, 1 step -> 0000000001.
- Pause: 2 ticks counted, i_Pause=1, 5 ticks, i_Pause=0, 2 more ticks -> exactly one move, occurring on the 4th counted tick.
- Load collision: i_Load=1 with i_Pattern=1111100000 in the same cycle as the 4th tick -> o_Lane=1111100000, no rotation, o_Step=0, next move requires 4 further ticks.
- Hit: lane 0000001000, i_Frog_Col=3 -> o_Hit=1 one cycle later. i_Frog_Col=12 -> o_Hit=0. After the next move (DIRECTION=0, bit 3 -> column 2) with i_Frog_Col=3 -> o_Hit=0.
- Async reset asserted mid-RUN, between clock edges, with counter=3 -> outputs reset immediately without waiting for a clock edge. After release, lane = INIT_PATTERN and state = IDLE; ticks cause no motion until i_Start.
